// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stages: ALU operation codes, forwarding selects
// and the control bundle that a bubble loads into a pipeline register.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_NOR   = 4'b0101,
    ALU_NAND  = 4'b0110,
    ALU_XNOR  = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_ROL   = 4'b1011,
    ALU_ROR   = 4'b1100,
    ALU_PASSA = 4'b1101,
    ALU_SLT   = 4'b1110,
    ALU_SLTU  = 4'b1111
  } alu_sel_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

  // A bubble is an instruction that has no side effects anywhere downstream.
  localparam ctrl_t BUBBLE_CTRL = '{valid: 1'b0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/forwarding_unit.sv
// Chooses the source of each EX operand: the younger EX/MEM producer beats MEM/WB,
// and register x0 or a non-writing producer never forwards.
module forwarding_unit
  import pipe_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  output fwd_sel_e      fwd_a_sel,
  output fwd_sel_e      fwd_b_sel
);

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (ex_rs1 != '0) begin
      if (exmem_reg_write && (exmem_rd == ex_rs1)) begin
        fwd_a_sel = FWD_EXMEM;
      end else if (memwb_reg_write && (memwb_rd == ex_rs1)) begin
        fwd_a_sel = FWD_MEMWB;
      end
    end
    if (ex_rs2 != '0) begin
      if (exmem_reg_write && (exmem_rd == ex_rs2)) begin
        fwd_b_sel = FWD_EXMEM;
      end else if (memwb_reg_write && (memwb_rd == ex_rs2)) begin
        fwd_b_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall/bubble logic.
// Define STAGE_PERF_EN to add saturating stall/flush performance counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int n  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [n-1:0]  id_pc,
  input  logic [n-1:0]  id_rs1_data,
  input  logic [n-1:0]  id_rs2_data,
  input  logic [n-1:0]  id_imm,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic [3:0]    id_alu_sel,
  input  logic          id_alu_src,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_reg_write,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [n-1:0]  exmem_alu_out,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [n-1:0]  memwb_wdata,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [n-1:0]  ex_pc,
  output logic [n-1:0]  ex_alu_a,
  output logic [n-1:0]  ex_alu_b,
  output logic [3:0]    ex_alu_sel,
  output logic [n-1:0]  ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_reg_write
`ifdef STAGE_PERF_EN
  ,
  output logic [31:0]   perf_stalls,
  output logic [31:0]   perf_flushes
`endif
);

  ctrl_t         ex_ctrl;
  logic [n-1:0]  ex_rs1_data;
  logic [n-1:0]  ex_rs2_data;
  logic [n-1:0]  ex_imm;
  logic [RW-1:0] ex_rs1;
  logic [RW-1:0] ex_rs2;
  logic          ex_alu_src;
  logic          load_bubble;
  logic [n-1:0]  fwd_rs1;
  logic [n-1:0]  fwd_rs2;
  fwd_sel_e      fwd_a_sel;
  fwd_sel_e      fwd_b_sel;

  // A load in EX cannot supply its data until MEM/WB, so a dependent ID instruction waits.
  assign stall_id = id_valid & ex_ctrl.valid & ex_ctrl.mem_read & (ex_rd != '0)
                  & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush;
  assign load_bubble = flush | stall_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl     <= BUBBLE_CTRL;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_alu_sel  <= ALU_ADD;
      ex_alu_src  <= 1'b0;
    end else if (load_bubble) begin
      ex_ctrl     <= BUBBLE_CTRL;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_alu_sel  <= ALU_ADD;
      ex_alu_src  <= 1'b0;
    end else begin
      ex_ctrl     <= '{valid: id_valid, mem_read: id_mem_read,
                       mem_write: id_mem_write, reg_write: id_reg_write};
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_alu_sel  <= id_alu_sel;
      ex_alu_src  <= id_alu_src;
    end
  end

  forwarding_unit #(.RW(RW)) u_fwd (
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
  );

  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
    case (fwd_a_sel)
      FWD_EXMEM: fwd_rs1 = exmem_alu_out;
      FWD_MEMWB: fwd_rs1 = memwb_wdata;
      default:   fwd_rs1 = ex_rs1_data;
    endcase
    case (fwd_b_sel)
      FWD_EXMEM: fwd_rs2 = exmem_alu_out;
      FWD_MEMWB: fwd_rs2 = memwb_wdata;
      default:   fwd_rs2 = ex_rs2_data;
    endcase
  end

  assign ex_alu_a      = fwd_rs1;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_b      = ex_alu_src ? ex_imm : fwd_rs2;
  assign ex_valid      = ex_ctrl.valid;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_reg_write  = ex_ctrl.reg_write;

`ifdef STAGE_PERF_EN
  // Counters stick at all-ones rather than wrapping so long runs never under-report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (stall_id && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      if (flush && (perf_flushes != 32'hFFFF_FFFF)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
